// File: rtl/gato_move_sequencer.sv
// Tic-tac-toe game controller: board, cursor, turn sequencing and a one-line-per-clock win/tie scan.
// Optional turn timeout enabled by defining GATO_TURN_TIMEOUT_EN.
module gato_move_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 250000000,
  parameter int unsigned TIMEOUT_W      = 28
) (
  input  logic        clk,
  input  logic        reset_all,
  input  logic        new_game,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  output logic [3:0]  cuadro,
  output logic [17:0] board_out,
  output logic [2:0]  state,
  output logic        turno_p1,
  output logic        turno_p2,
  output logic [3:0]  win_line,
  output logic        move_reject,
  output logic        timeout_pulse
);

  typedef enum logic [2:0] {
    S_PLAY   = 3'd0,
    S_CHECK  = 3'd1,
    S_P1_WIN = 3'd2,
    S_P2_WIN = 3'd3,
    S_TIE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  cuadro_q, cuadro_d;
  logic        turn_p1_q, turn_p1_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  moves_q, moves_d;
  logic [3:0]  win_q, win_d;
  logic        reject_q, reject_d;
  logic [1:0]  code;
  logic [3:0]  la, lb, lc;
  logic        line_hit;

`ifdef GATO_TURN_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] idle_q, idle_d;
  logic                 tpulse_q, tpulse_d;
  logic                 any_btn;
  assign any_btn = btn_select | btn_up | btn_down | btn_left | btn_right;
`endif

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction

  assign code = turn_p1_q ? 2'b01 : 2'b10;

  always_comb begin
    la = 4'd0; lb = 4'd1; lc = 4'd2;
    case (idx_q)
      3'd0: begin la = 4'd0; lb = 4'd1; lc = 4'd2; end
      3'd1: begin la = 4'd3; lb = 4'd4; lc = 4'd5; end
      3'd2: begin la = 4'd6; lb = 4'd7; lc = 4'd8; end
      3'd3: begin la = 4'd0; lb = 4'd3; lc = 4'd6; end
      3'd4: begin la = 4'd1; lb = 4'd4; lc = 4'd7; end
      3'd5: begin la = 4'd2; lb = 4'd5; lc = 4'd8; end
      3'd6: begin la = 4'd0; lb = 4'd4; lc = 4'd8; end
      default: begin la = 4'd2; lb = 4'd4; lc = 4'd6; end
    endcase
  end

  assign line_hit = (cell_at(board_q, la) == code) && (cell_at(board_q, lb) == code) &&
                    (cell_at(board_q, lc) == code);

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    cuadro_d  = cuadro_q;
    turn_p1_d = turn_p1_q;
    idx_d     = idx_q;
    moves_d   = moves_q;
    win_d     = win_q;
    reject_d  = 1'b0;
`ifdef GATO_TURN_TIMEOUT_EN
    idle_d    = '0;
    tpulse_d  = 1'b0;
`endif
    case (state_q)
      S_PLAY: begin
`ifdef GATO_TURN_TIMEOUT_EN
        if (any_btn) begin
          idle_d = '0;
        end else if (idle_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          idle_d    = '0;
          tpulse_d  = 1'b1;
          turn_p1_d = ~turn_p1_q;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
        // The highest-priority button owns the cycle even when its move saturates.
        if (btn_select) begin
          if (cell_at(board_q, cuadro_q) != 2'b00) begin
            reject_d = 1'b1;
          end else begin
            board_d[{cuadro_q, 1'b0} +: 2] = code;
            moves_d = moves_q + 4'd1;
            idx_d   = 3'd0;
            state_d = S_CHECK;
          end
        end else if (btn_up) begin
          if (cuadro_q >= 4'd3) cuadro_d = cuadro_q - 4'd3;
        end else if (btn_down) begin
          if (cuadro_q <= 4'd5) cuadro_d = cuadro_q + 4'd3;
        end else if (btn_left) begin
          if (cuadro_q != 4'd0 && cuadro_q != 4'd3 && cuadro_q != 4'd6) cuadro_d = cuadro_q - 4'd1;
        end else if (btn_right) begin
          if (cuadro_q != 4'd2 && cuadro_q != 4'd5 && cuadro_q != 4'd8) cuadro_d = cuadro_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (line_hit) begin
          state_d = turn_p1_q ? S_P1_WIN : S_P2_WIN;
          win_d   = {1'b0, idx_q};
        end else if (idx_q != 3'd7) begin
          idx_d = idx_q + 3'd1;
        end else if (moves_q == 4'd9) begin
          state_d = S_TIE;
        end else begin
          turn_p1_d = ~turn_p1_q;
          state_d   = S_PLAY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_all || new_game) begin
      state_q   <= S_PLAY;
      board_q   <= '0;
      cuadro_q  <= '0;
      turn_p1_q <= 1'b1;
      idx_q     <= '0;
      moves_q   <= '0;
      win_q     <= '1;
      reject_q  <= 1'b0;
`ifdef GATO_TURN_TIMEOUT_EN
      idle_q    <= '0;
      tpulse_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      cuadro_q  <= cuadro_d;
      turn_p1_q <= turn_p1_d;
      idx_q     <= idx_d;
      moves_q   <= moves_d;
      win_q     <= win_d;
      reject_q  <= reject_d;
`ifdef GATO_TURN_TIMEOUT_EN
      idle_q    <= idle_d;
      tpulse_q  <= tpulse_d;
`endif
    end
  end

  assign cuadro      = cuadro_q;
  assign board_out   = board_q;
  assign state       = state_q;
  assign turno_p1    = turn_p1_q;
  assign turno_p2    = ~turn_p1_q;
  assign win_line    = win_q;
  assign move_reject = reject_q;
`ifdef GATO_TURN_TIMEOUT_EN
  assign timeout_pulse = tpulse_q;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_gato_move_sequencer.sv
// Bench for gato_move_sequencer: game-level reference model compared every cycle, plus directed literal checks.
module tb_gato_move_sequencer;
  logic        clk = 1'b0;
  logic        reset_all = 1'b0;
  logic        new_game = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_select = 1'b0;
  logic [3:0]  cuadro;
  logic [17:0] board_out;
  logic [2:0]  state;
  logic        turno_p1, turno_p2;
  logic [3:0]  win_line;
  logic        move_reject, timeout_pulse;

  gato_move_sequencer dut (
    .clk(clk), .reset_all(reset_all), .new_game(new_game),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_select(btn_select), .cuadro(cuadro), .board_out(board_out), .state(state),
    .turno_p1(turno_p1), .turno_p2(turno_p2), .win_line(win_line),
    .move_reject(move_reject), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Game-level model: outcome of a move is decided at once; only its reporting time is delayed.
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int m_board [9];
  int m_cur, m_state, m_moves, m_win, m_rej, m_res, m_resline, m_wait;
  bit m_p1;

  task automatic model_clear();
    foreach (m_board[i]) m_board[i] = 0;
    m_cur = 0; m_state = 0; m_moves = 0; m_win = 15; m_rej = 0; m_p1 = 1;
    m_res = 0; m_resline = 15; m_wait = 0;
  endtask

  always @(posedge clk) begin
    int who, k;
    m_rej = 0;
    if (!reset_all || new_game) model_clear();
    else if (m_state == 0) begin
      if (btn_select) begin
        if (m_board[m_cur] != 0) m_rej = 1;
        else begin
          who = m_p1 ? 1 : 2;
          m_board[m_cur] = who;
          m_moves++;
          k = -1;
          for (int l = 7; l >= 0; l--)
            if (m_board[lines[l][0]] == who && m_board[lines[l][1]] == who && m_board[lines[l][2]] == who) k = l;
          if (k >= 0) begin m_res = m_p1 ? 2 : 3; m_resline = k; m_wait = k + 1; end
          else begin m_res = (m_moves == 9) ? 4 : 0; m_resline = 15; m_wait = 8; end
          m_state = 1;
        end
      end
      else if (btn_up)    begin if (m_cur >= 3) m_cur -= 3; end
      else if (btn_down)  begin if (m_cur <= 5) m_cur += 3; end
      else if (btn_left)  begin if (m_cur % 3 != 0) m_cur -= 1; end
      else if (btn_right) begin if (m_cur % 3 != 2) m_cur += 1; end
    end
    else if (m_state == 1) begin
      m_wait--;
      if (m_wait == 0) begin
        m_state = m_res;
        m_win = m_resline;
        if (m_res == 0) m_p1 = ~m_p1;
      end
    end
  end

  always @(negedge clk) begin
    int mb;
    if (started) begin
      mb = 0;
      for (int i = 0; i < 9; i++) mb |= m_board[i] << (2 * i);
      chk("cuadro", int'(cuadro), m_cur);
      chk("board_out", int'(board_out), mb);
      chk("state", int'(state), m_state);
      chk("turno_p1", int'(turno_p1), int'(m_p1));
      chk("turno_p2", int'(turno_p2), int'(!m_p1));
      chk("win_line", int'(win_line), m_win);
      chk("move_reject", int'(move_reject), m_rej);
      chk("timeout_pulse", int'(timeout_pulse), 0);
    end
  end

  // b: 0 select, 1 up, 2 down, 3 left, 4 right
  task automatic press(input int b);
    @(posedge clk); #2;
    case (b)
      0: btn_select = 1'b1; 1: btn_up = 1'b1; 2: btn_down = 1'b1;
      3: btn_left = 1'b1; default: btn_right = 1'b1;
    endcase
    @(posedge clk); #2;
    {btn_select, btn_up, btn_down, btn_left, btn_right} = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic fresh_game();
    @(posedge clk); #2 new_game = 1'b1;
    @(posedge clk); #2 new_game = 1'b0;
  endtask

  task automatic goto_cell(input int c);
    int cr;
    cr = m_cur;
    while (cr / 3 > c / 3) begin press(1); cr -= 3; end
    while (cr / 3 < c / 3) begin press(2); cr += 3; end
    while (cr % 3 > c % 3) begin press(3); cr -= 1; end
    while (cr % 3 < c % 3) begin press(4); cr += 1; end
  endtask

  task automatic play(input int c);
    goto_cell(c);
    press(0);
    wait_cycles(10);
  endtask

  int tie_order [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    reset_all = 1'b0;
    repeat (2) @(posedge clk);
    #2 started = 1;
    @(negedge clk);
    chk("rst_cuadro", int'(cuadro), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_turno_p1", int'(turno_p1), 1);
    chk("rst_win_line", int'(win_line), 15);
    #2 reset_all = 1'b1;

    // Cursor walk and edge saturation
    press(4); press(4); press(2);
    @(negedge clk); chk("cur_walk", int'(cuadro), 5);
    press(4);
    @(negedge clk); chk("cur_right_sat", int'(cuadro), 5);
    press(1); press(1);
    @(negedge clk); chk("cur_up_sat", int'(cuadro), 2);
    press(3); press(2); press(2); press(2); press(3); press(3);
    @(negedge clk); chk("cur_corner", int'(cuadro), 6);

    // P1 wins on line 0
    fresh_game();
    play(0); play(3); play(1); play(4);
    goto_cell(2);
    press(0);
    @(negedge clk);
    chk("win_board_visible", int'(board_out[5:0]), 6'b010101);
    chk("win_in_check", int'(state), 1);
    chk("win_mover_p1", int'(turno_p1), 1);
    @(negedge clk);
    chk("win_state", int'(state), 2);
    chk("win_line0", int'(win_line), 0);
    press(2); press(0);
    @(negedge clk); chk("win_terminal", int'(state), 2);

    // Reject on occupied cell
    fresh_game();
    play(4);
    press(0);
    @(negedge clk);
    chk("reject_pulse", int'(move_reject), 1);
    chk("reject_state", int'(state), 0);
    chk("reject_turn_p2", int'(turno_p2), 1);
    @(negedge clk); chk("reject_one_cycle", int'(move_reject), 0);

    // Full board with no line -> tie
    fresh_game();
    for (int i = 0; i < 8; i++) play(tie_order[i]);
    goto_cell(8);
    press(0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("tie_check_phase", int'(state), 1);
    end
    @(negedge clk); chk("tie_state", int'(state), 4);
    press(3); press(0);
    @(negedge clk);
    chk("tie_btn_ignored", int'(cuadro), 8);
    chk("tie_terminal", int'(state), 4);

    // new_game mid-check aborts the scan
    fresh_game();
    play(0);
    press(0); // P2 on the already-occupied cell 0 -> reject
    goto_cell(8);
    press(0);
    wait_cycles(1);
    #0 new_game = 1'b1;
    @(posedge clk); #2 new_game = 1'b0;
    @(negedge clk);
    chk("ng_board", int'(board_out), 0);
    chk("ng_state", int'(state), 0);
    chk("ng_turno_p1", int'(turno_p1), 1);
    wait_cycles(3);

    started = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gato_move_sequencer.md
Name: gato_move_sequencer

Overview:
Game-play controller for the tic-tac-toe (gato) board, between the button synchronizer and the graphics generator.
- Owns the 9-cell board register file and the selection cursor.
- Sequences player moves and alternates turns.
- Runs a multi-cycle line scan (one line per clock) to detect a win or a tie.
- Exports the board, cursor and game state for rendering.

Parameters:
TIMEOUT_CYCLES, 250000000, clk cycles a player may stay idle before the turn passes (used only with the optional feature).
TIMEOUT_W, 28, width of the idle counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_all  input  1  synchronous, active-low reset.
new_game  input  1  synchronous game clear, active-high, level.
btn_up  input  1  one-cycle pulse from the synchronizer.
btn_down  input  1  one-cycle pulse.
btn_left  input  1  one-cycle pulse.
btn_right  input  1  one-cycle pulse.
btn_select  input  1  one-cycle pulse; commit move at cursor.
cuadro  output  4  cursor cell index 0..8, row-major.
board_out  output  18  cell i at [2i+1:2i]; 00 empty, 01 P1, 10 P2, 11 never produced.
state  output  3  0 PLAY, 1 CHECK, 2 P1_WIN, 3 P2_WIN, 4 TIE.
turno_p1  output  1  high while P1 to move.
turno_p2  output  1  high while P2 to move; never high together with turno_p1.
win_line  output  4  winning line 0..7 in P1_WIN/P2_WIN; 4'hF otherwise.
move_reject  output  1  one-cycle pulse when select hits an occupied cell.
timeout_pulse  output  1  one-cycle pulse when a turn is forfeited on timeout.

Behaviour:
- Reset (reset_all=0 at an edge) sets: board all 00, cuadro=0, state=PLAY, turno_p1=1, turno_p2=0, win_line=F, pulses 0, move count 0, idle counter 0.
- new_game=1 has the same effect as reset, from any state, including mid-CHECK. Priority: reset > new_game > buttons.
- Buttons act only in PLAY; ignored in every other state.
- One action per cycle, priority select > up > down > left > right.
- Cursor movement saturates at the board edges, no wrap:
  - up: if cuadro>=3 then -3.
  - down: if cuadro<=5 then +3.
  - left: if cuadro mod 3 != 0 then -1.
  - right: if cuadro mod 3 != 2 then +1.
- Select on an empty cell:
  - Write the current player's code (P1=01, P2=10) at the next edge.
  - Increment move count.
  - Set state=CHECK with scan index 0.
- Select on an occupied cell: board unchanged, move_reject=1 for one cycle, state stays PLAY.
- CHECK: each cycle evaluates line[idx] against the mover's code. Lines in order:
  - 0: {0,1,2}, 1: {3,4,5}, 2: {6,7,8}
  - 3: {0,3,6}, 4: {1,4,7}, 5: {2,5,8}
  - 6: {0,4,8}, 7: {2,4,6}
- CHECK transitions:
  - Match: next state P1_WIN or P2_WIN per mover; win_line=idx.
  - No match and idx<7: idx+1.
  - No match, idx=7, move count=9: TIE.
  - No match, idx=7, move count<9: toggle turn, return to PLAY.
- Latency from the select edge at cycle t:
  - Board visible at t+1.
  - Worst-case return to PLAY or TIE at t+9.
  - Win on line k reported at t+2+k.
- A ninth move that completes a line reports a WIN, not a TIE.
- P1_WIN, P2_WIN and TIE are terminal until reset or new_game. Turn outputs freeze in these states.
- Both turn outputs stay valid during CHECK and show the mover.

Optional Feature:
Macro GATO_TURN_TIMEOUT_EN.
- Defined:
  - In PLAY, the idle counter increments each cycle.
  - It clears on any accepted button action (including a reject) and on entering PLAY.
  - When it reaches TIMEOUT_CYCLES-1 with no button that cycle: toggle turn, timeout_pulse=1 for one cycle, counter to 0. Board and cursor are unchanged.
  - The counter holds at 0 outside PLAY.
- Undefined: no counter logic; timeout_pulse is tied to 0.

Test Plan:
- Reset, then right, right, down -> cuadro 0→1→2→5. Further right keeps 5; up from 2 keeps 2.
- P1 select cells 0 and 1 and P2 select cells 3 and 4, alternating; P1 select cell 2 -> board_out[5:0]=010101, state=P2_WIN? no: P1_WIN, win_line=0, reported 2 cycles after the select edge.
- Select an occupied cell -> move_reject pulse, board and turn unchanged, state stays 0.
- Fill moves in order 0,1,2,4,3,5,7,6,8 (alternating P1/P2, no line) -> state=TIE 9 cycles after the last select. Buttons are then ignored.
- Assert new_game during CHECK (cycle t+3) -> next edge: board all 0, state=PLAY, turno_p1=1.
- With GATO_TURN_TIMEOUT_EN and TIMEOUT_CYCLES=16, idle in PLAY -> timeout_pulse after 16 cycles and turno_p2=1. A button at cycle 10 restarts the count.
